// File: rtl/bist_response_checker.sv
// ============================================================================
// Module      : bist_response_checker
// Description : Checks per-pattern DUT responses against a golden table,
//               counts mismatches, captures the first failing pattern and
//               compacts all responses into a 16-bit MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bist_response_checker #(
    parameter int                              N_IN   = 3,
    parameter int                              N_OUT  = 2,
    parameter logic [(2**N_IN)*N_OUT-1:0]      GOLDEN = 16'h1B1B,
    parameter int                              CW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [N_IN-1:0]   in_idx_i,
    input  logic [N_OUT-1:0]  in_resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [CW-1:0]     err_count_o,
    output logic              seq_err_o,
    output logic              first_fail_valid_o,
    output logic [N_IN-1:0]   first_fail_idx_o,
    output logic [15:0]       signature_o
);

    localparam int              C_NPAT     = 2**N_IN;
    localparam logic [N_IN-1:0] C_LAST_IDX = N_IN'(C_NPAT - 1);
    localparam logic [15:0]     C_MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     err_q, err_d;
    logic              seq_err_q, seq_err_d;
    logic              ffv_q, ffv_d;
    logic [N_IN-1:0]   ffi_q, ffi_d;
    logic [N_IN-1:0]   exp_idx_q, exp_idx_d;
    logic [15:0]       sig_q, sig_d;

    logic              w_accept;
    logic [N_OUT-1:0]  w_golden;
    logic              w_mismatch;
    logic [15:0]       w_sig_next;

    assign w_accept = (state_q == S_RUN) && in_valid_i && !start_i;

    // Constant-base table lookup keeps the index arithmetic out of the select.
    always_comb begin
        w_golden = '0;
        for (int k = 0; k < C_NPAT; k++) begin
            if (exp_idx_q == k[N_IN-1:0]) begin
                w_golden = GOLDEN[k*N_OUT +: N_OUT];
            end
        end
    end

    assign w_mismatch = (in_resp_i != w_golden) || (in_idx_i != exp_idx_q);
    assign w_sig_next = {sig_q[14:0], 1'b0}
                      ^ (sig_q[15] ? C_MISR_POLY : 16'h0000)
                      ^ 16'(in_resp_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            err_q     <= '0;
            seq_err_q <= 1'b0;
            ffv_q     <= 1'b0;
            ffi_q     <= '0;
            exp_idx_q <= '0;
            sig_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            seq_err_q <= seq_err_d;
            ffv_q     <= ffv_d;
            ffi_q     <= ffi_d;
            exp_idx_q <= exp_idx_d;
            sig_q     <= sig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        seq_err_d = seq_err_q;
        ffv_d     = ffv_q;
        ffi_d     = ffi_q;
        exp_idx_d = exp_idx_q;
        sig_d     = sig_q;

        if (start_i) begin
            // Restart from any state; a response on this cycle is dropped.
            state_d   = S_RUN;
            err_d     = '0;
            seq_err_d = 1'b0;
            ffv_d     = 1'b0;
            ffi_d     = '0;
            exp_idx_d = '0;
            sig_d     = 16'hFFFF;
        end else if (w_accept) begin
            exp_idx_d = exp_idx_q + N_IN'(1);
            sig_d     = w_sig_next;
            if (in_idx_i != exp_idx_q) begin
                seq_err_d = 1'b1;
            end
            if (w_mismatch) begin
                if (err_q != {CW{1'b1}}) begin
                    err_d = err_q + CW'(1);
                end
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffi_d = exp_idx_q;
                end
            end
            if (exp_idx_q == C_LAST_IDX) begin
                state_d = S_DONE;
            end
        end
    end

    assign busy_o             = (state_q == S_RUN);
    assign done_o             = (state_q == S_DONE);
    assign pass_o             = (state_q == S_DONE) && (err_q == '0) && !seq_err_q;
    assign err_count_o        = err_q;
    assign seq_err_o          = seq_err_q;
    assign first_fail_valid_o = ffv_q;
    assign first_fail_idx_o   = ffi_q;
    assign signature_o        = sig_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_response_checker.sv
// ============================================================================
// Module      : tb_bist_response_checker
// Description : Self-checking bench with a run-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bist_response_checker;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int NPAT  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_idx = '0;
    logic [1:0]  in_resp = '0;

    logic        busy, done, pass, seq_err, ffv;
    logic [3:0]  err_count;
    logic [2:0]  ffi;
    logic [15:0] signature;

    logic        busy2, done2, pass2, seq_err2, ffv2;
    logic [1:0]  err_count2;
    logic [2:0]  ffi2;
    logic [15:0] signature2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bist_response_checker #(.N_IN(3), .N_OUT(2), .GOLDEN(16'h1B1B), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_idx_i(in_idx), .in_resp_i(in_resp),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
        .seq_err_o(seq_err), .first_fail_valid_o(ffv), .first_fail_idx_o(ffi),
        .signature_o(signature));

    bist_response_checker #(.N_IN(3), .N_OUT(2), .GOLDEN(16'h1B1B), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .in_valid_i(in_valid),
        .in_idx_i(in_idx), .in_resp_i(in_resp),
        .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_count_o(err_count2),
        .seq_err_o(seq_err2), .first_fail_valid_o(ffv2), .first_fail_idx_o(ffi2),
        .signature_o(signature2));

    // Reference model: a run is the list of responses accepted since start.
    int          m_state = 0;          // 0 idle, 1 running, 2 finished
    logic [1:0]  q_resp[$];
    logic [2:0]  q_idx[$];
    logic [15:0] m_init = 16'h0000;

    function automatic logic [1:0] gold(input int k);
        logic [2:0] kk;
        kk = 3'(k);
        return ~kk[1:0];
    endfunction

    function automatic logic bad(input int k);
        return (q_resp[k] != gold(k)) || (q_idx[k] != 3'(k));
    endfunction

    function automatic int exp_err();
        int c = 0;
        for (int k = 0; k < q_resp.size(); k++) if (bad(k)) c++;
        return c;
    endfunction

    function automatic int exp_first();
        for (int k = 0; k < q_resp.size(); k++) if (bad(k)) return k;
        return -1;
    endfunction

    function automatic logic exp_seq();
        for (int k = 0; k < q_idx.size(); k++) if (q_idx[k] != 3'(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_sig();
        logic [15:0] s = m_init;
        for (int k = 0; k < q_resp.size(); k++)
            s = (s << 1) ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, q_resp[k]};
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            q_resp.delete();
            q_idx.delete();
            m_init = 16'h0000;
        end else if (start) begin
            m_state = 1;
            q_resp.delete();
            q_idx.delete();
            m_init = 16'hFFFF;
        end else if (m_state == 1 && in_valid) begin
            q_resp.push_back(in_resp);
            q_idx.push_back(in_idx);
            if (q_resp.size() == NPAT) m_state = 2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int e, f;
        logic s;
        e = exp_err();
        f = exp_first();
        s = exp_seq();
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("done", 32'(done), 32'(m_state == 2));
        chk("pass", 32'(pass), 32'(m_state == 2 && e == 0 && !s));
        chk("err_count", 32'(err_count), 32'((e > 15) ? 15 : e));
        chk("err_count_cw2", 32'(err_count2), 32'((e > 3) ? 3 : e));
        chk("seq_err", 32'(seq_err), 32'(s));
        chk("ff_valid", 32'(ffv), 32'(f >= 0));
        chk("ff_idx", 32'(ffi), 32'((f >= 0) ? f : 0));
        chk("signature", 32'(signature), 32'(exp_sig()));
        chk("signature_cw2", 32'(signature2), 32'(exp_sig()));
    end

    task automatic cyc(input logic s, input logic v, input logic [2:0] idx, input logic [1:0] r);
        start    = s;
        in_valid = v;
        in_idx   = idx;
        in_resp  = r;
        @(posedge clk);
        #1;
    endtask

    // mode 0 correct, 1 k=5 wrong, 2 all zero, 3 index swap 2/3
    task automatic run(input int mode);
        logic [2:0] idx;
        logic [2:0] kk;
        cyc(1'b1, 1'b0, 3'd0, 2'd0);
        for (int k = 0; k < NPAT; k++) begin
            kk  = 3'(k);
            idx = kk;
            if (mode == 3 && k == 2) idx = 3'd3;
            if (mode == 3 && k == 3) idx = 3'd2;
            case (mode)
                1:       cyc(1'b0, 1'b1, idx, (k == 5) ? 2'b11 : ~kk[1:0]);
                2:       cyc(1'b0, 1'b1, idx, 2'b00);
                default: cyc(1'b0, 1'b1, idx, ~idx[1:0]);
            endcase
        end
    endtask

    initial begin
        logic [2:0] kk;
        int acc;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sig", 32'(signature), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        cyc(1'b0, 1'b1, 3'd3, 2'd1);
        chk("idle_valid_err", 32'(err_count), 32'h0);
        chk("idle_valid_sig", 32'(signature), 32'h0);
        chk("idle_valid_busy", 32'(busy), 32'h0);

        run(0);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_pass", 32'(pass), 32'h1);
        chk("t1_err", 32'(err_count), 32'h0);
        chk("t1_ffv", 32'(ffv), 32'h0);
        cyc(1'b0, 1'b1, 3'd0, 2'd0);
        chk("done_hold_valid", 32'(done), 32'h1);

        run(1);
        chk("t2_err", 32'(err_count), 32'h1);
        chk("t2_ffi", 32'(ffi), 32'h5);
        chk("t2_ffv", 32'(ffv), 32'h1);
        chk("t2_pass", 32'(pass), 32'h0);

        run(2);
        chk("t3_err", 32'(err_count), 32'h6);
        chk("t3_ffi", 32'(ffi), 32'h0);
        chk("t3_pass", 32'(pass), 32'h0);
        chk("t5_sat", 32'(err_count2), 32'h3);

        run(3);
        chk("t4_seq", 32'(seq_err), 32'h1);
        chk("t4_err", 32'(err_count), 32'h2);
        chk("t4_ffi", 32'(ffi), 32'h2);
        chk("t4_pass", 32'(pass), 32'h0);

        // Reset after four accepts
        cyc(1'b1, 1'b0, 3'd0, 2'd0);
        for (int k = 0; k < 4; k++) begin
            kk = 3'(k);
            cyc(1'b0, 1'b1, kk, 2'b00);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_err", 32'(err_count), 32'h0);
        chk("midrst_ffv", 32'(ffv), 32'h0);
        chk("midrst_sig", 32'(signature), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Restart after three accepts, start coincident with a response
        cyc(1'b1, 1'b0, 3'd0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            kk = 3'(k);
            cyc(1'b0, 1'b1, kk, 2'b00);
        end
        cyc(1'b1, 1'b1, 3'd3, 2'b00);
        chk("restart_err", 32'(err_count), 32'h0);
        chk("restart_sig", 32'(signature), 32'hFFFF);
        for (int k = 0; k < NPAT; k++) begin
            kk = 3'(k);
            cyc(1'b0, 1'b1, kk, ~kk[1:0]);
        end
        chk("restart_pass", 32'(pass), 32'h1);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            cyc(1'b1, 1'b0, 3'd0, 2'd0);
            acc = 0;
            for (int c = 0; c < 40 && acc < NPAT; c++) begin
                logic v, s;
                logic [2:0] idx;
                logic [1:0] rsp;
                kk  = 3'(acc);
                v   = ($urandom_range(0, 3) != 0);
                s   = ($urandom_range(0, 49) == 0);
                idx = ($urandom_range(0, 9) == 0) ? 3'($urandom) : kk;
                rsp = ($urandom_range(0, 4) == 0) ? 2'($urandom) : ~kk[1:0];
                cyc(s, v, idx, rsp);
                if (s) acc = 0;
                else if (v) acc++;
            end
            cyc(1'b0, 1'($urandom), 3'($urandom), 2'($urandom));
            cyc(1'b0, 1'($urandom), 3'($urandom), 2'($urandom));
        end

        cyc(1'b0, 1'b0, 3'd0, 2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
